bram_burst_reader: RTL and testbench

- Read-side BRAM controller feeding the instruction cache line fill.
- On a miss request from the arbiter, issues BURST_LEN consecutive word reads to the fixed-latency user BRAM, pipelined at one address per cycle.
- Returns each word with a one-cycle valid strobe on out_data/out_valid. These connect directly to the cache's bram_data_in/bram_in_valid.
- Read-only, one burst in flight, no abort.

---
 rtl/bram_burst_reader_pkg.sv | 16 +
 rtl/bram_burst_reader_lat_pipe.sv | 32 +++
 rtl/bram_burst_reader.sv | 116 +++++++++++
 tb/tb_bram_burst_reader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_burst_reader_pkg.sv
// Shared constants for the instruction-cache line-fill path: FSM encoding and
// the default burst geometry and BRAM timing.
package bram_burst_reader_pkg;

    localparam int BRB_BURST_LEN    = 8;
    localparam int BRB_BRAM_LATENCY = 10;
    localparam int BRB_ADDR_W       = 13;
    localparam int BRB_OFF_W        = $clog2(BRB_BURST_LEN);

    typedef logic [1:0] brb_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/bram_burst_reader_lat_pipe.sv
// Valid-bit delay line that tags each issued BRAM read until its data
// appears on the BRAM read port.
module bram_lat_pipe
    import bram_burst_reader_pkg::*;
#(
    parameter int DEPTH = BRB_BRAM_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tag,
    output logic o_tag
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sr <= '0;
                else        r_sr <= i_tag;
            end
        end else begin : g_many
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sr <= '0;
                else        r_sr <= {r_sr[DEPTH-2:0], i_tag};
            end
        end
    endgenerate

    assign o_tag = r_sr[DEPTH-1];

endmodule

// File: rtl/bram_burst_reader.sv
// Line-fill reader: on a cache miss, streams BURST_LEN aligned words out of a
// fixed-latency BRAM and hands them back one per cycle.
module bram_burst_reader
    import bram_burst_reader_pkg::*;
#(
    parameter int BURST_LEN    = BRB_BURST_LEN,
    parameter int BRAM_LATENCY = BRB_BRAM_LATENCY,
    parameter int ADDR_W       = BRB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [31:0]       bram_rdata,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic              burst_done,
    output logic              busy
);

    localparam int OFF_W = $clog2(BURST_LEN);
    localparam int CNT_W = OFF_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST_M1 = CNT_W'(BURST_LEN - 1);

    brb_state_t        r_state;
    logic              r_bram_en;
    logic [ADDR_W-1:0] r_bram_addr;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [CNT_W-1:0]  r_ret_cnt;
    logic              r_out_valid;
    logic [31:0]       r_out_data;
    logic              r_burst_done;

    logic [ADDR_W-1:0] w_word;
    logic [ADDR_W-1:0] w_base;
    logic              w_tag;
    logic              w_unused;

    // Byte address -> word address, snapped to the start of the cache line.
    assign w_word   = req_addr[ADDR_W+1:2];
    assign w_base   = {w_word[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_unused = ^{req_addr[31:ADDR_W+2], req_addr[1:0], w_word[OFF_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
            r_issue_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_state     <= ST_ISSUE;
                        r_bram_en   <= 1'b1;
                        r_bram_addr <= w_base;
                        r_issue_cnt <= CNT_W'(1);
                    end
                end
                ST_ISSUE: begin
                    if (r_issue_cnt == CNT_LAST) begin
                        r_state     <= ST_DRAIN;
                        r_bram_en   <= 1'b0;
                        r_issue_cnt <= '0;
                    end else begin
                        r_bram_addr <= r_bram_addr + ADDR_W'(1);
                        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_ret_cnt == CNT_LAST) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The tag enters on the edge where the BRAM samples the read.
    bram_lat_pipe #(.DEPTH(BRAM_LATENCY)) u_lat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tag (r_bram_en),
        .o_tag (w_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_burst_done <= 1'b0;
            r_ret_cnt    <= '0;
        end else begin
            r_out_valid  <= w_tag;
            r_burst_done <= w_tag && (r_ret_cnt == CNT_LAST_M1);
            if (w_tag) begin
                r_out_data <= bram_rdata;
                r_ret_cnt  <= r_ret_cnt + CNT_W'(1);
            end else if (r_state == ST_DRAIN && r_ret_cnt == CNT_LAST) begin
                r_ret_cnt <= '0;
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign bram_en    = r_bram_en;
    assign bram_addr  = r_bram_addr;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign burst_done = r_burst_done;

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: three instances cover the default geometry and
// the latency/burst-length extremes against a timing-rule reference model.
module tb_bram_burst_reader;

    localparam int AW   = 13;
    localparam int BL0  = 8;
    localparam int LAT0 = 10;
    localparam int BL1  = 4;
    localparam int LAT1 = 1;
    localparam int BL2  = 16;
    localparam int LAT2 = 31;

    logic clk;
    logic rst_n;

    logic rv0, rr0, ben0, ov0, bd0, busy0;
    logic rv1, rr1, ben1, ov1, bd1, busy1;
    logic rv2, rr2, ben2, ov2, bd2, busy2;
    logic [31:0] ra0, rd0, od0;
    logic [31:0] ra1, rd1, od1;
    logic [31:0] ra2, rd2, od2;
    logic [AW-1:0] badr0, badr1, badr2;

    int nrun  = 0;
    int nfail = 0;

    bram_burst_reader #(.BURST_LEN(BL0), .BRAM_LATENCY(LAT0), .ADDR_W(AW)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rr0), .req_addr(ra0),
        .bram_en(ben0), .bram_addr(badr0), .bram_rdata(rd0), .out_valid(ov0),
        .out_data(od0), .burst_done(bd0), .busy(busy0));

    bram_burst_reader #(.BURST_LEN(BL1), .BRAM_LATENCY(LAT1), .ADDR_W(AW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_addr(ra1),
        .bram_en(ben1), .bram_addr(badr1), .bram_rdata(rd1), .out_valid(ov1),
        .out_data(od1), .burst_done(bd1), .busy(busy1));

    bram_burst_reader #(.BURST_LEN(BL2), .BRAM_LATENCY(LAT2), .ADDR_W(AW)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_ready(rr2), .req_addr(ra2),
        .bram_en(ben2), .bram_addr(badr2), .bram_rdata(rd2), .out_valid(ov2),
        .out_data(od2), .burst_done(bd2), .busy(busy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'd3;
    endfunction

    // BRAM models: the word sampled on edge S is on rdata in the cycle after S+L-1.
    logic [31:0] d0 [32];
    logic [31:0] d1 [32];
    logic [31:0] d2 [32];
    always @(posedge clk) begin
        for (int j = 31; j > 0; j--) begin
            d0[j] <= d0[j-1];
            d1[j] <= d1[j-1];
            d2[j] <= d2[j-1];
        end
        d0[0] <= ben0 ? mem_word(32'(badr0)) : 32'hDEAD_BEEF;
        d1[0] <= ben1 ? mem_word(32'(badr1)) : 32'hDEAD_BEEF;
        d2[0] <= ben2 ? mem_word(32'(badr2)) : 32'hDEAD_BEEF;
    end
    assign rd0 = d0[LAT0-1];
    assign rd1 = d1[LAT1-1];
    assign rd2 = d2[LAT2-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nrun++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [31:0] a);
        case (i)
            0: begin rv0 = v; ra0 = a; end
            1: begin rv1 = v; ra1 = a; end
            default: begin rv2 = v; ra2 = a; end
        endcase
    endtask

    task automatic sample(input int i, output logic rr, output logic ben,
                          output logic [31:0] badr, output logic ov,
                          output logic [31:0] od, output logic bd, output logic bz);
        case (i)
            0: begin rr = rr0; ben = ben0; badr = 32'(badr0); ov = ov0; od = od0; bd = bd0; bz = busy0; end
            1: begin rr = rr1; ben = ben1; badr = 32'(badr1); ov = ov1; od = od1; bd = bd1; bz = busy1; end
            default: begin rr = rr2; ben = ben2; badr = 32'(badr2); ov = ov2; od = od2; bd = bd2; bz = busy2; end
        endcase
    endtask

    function automatic int blen(input int i);
        return (i == 0) ? BL0 : (i == 1) ? BL1 : BL2;
    endfunction

    function automatic int blat(input int i);
        return (i == 0) ? LAT0 : (i == 1) ? LAT1 : LAT2;
    endfunction

    // Present a request in an idle cycle; returns just after the acceptance edge E.
    task automatic issue_req(input int i, input logic [31:0] addr);
        logic rr, ben, ov, bd, bz;
        logic [31:0] badr, od;
        @(negedge clk);
        drive(i, 1'b1, addr);
        sample(i, rr, ben, badr, ov, od, bd, bz);
        chk("req_ready_idle", 32'(rr), 32'd1);
        @(posedge clk);
    endtask

    // Cycle c is the cycle after edge E+c: issue while c<B, word k=c-L-1 returned.
    task automatic check_burst(input int i, input logic [31:0] addr,
                               input bit hold, input logic [31:0] haddr);
        logic rr, ben, ov, bd, bz;
        logic [31:0] badr, od;
        int B, L, k, ndone;
        logic [31:0] base;
        B = blen(i);
        L = blat(i);
        base = ((addr >> 2) % (32'd1 << AW)) / 32'(B) * 32'(B);
        ndone = 0;
        for (int c = 0; c <= L + B + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (hold) drive(i, 1'b1, haddr);
                else      drive(i, 1'b0, 32'h0);
            end
            sample(i, rr, ben, badr, ov, od, bd, bz);
            k = c - L - 1;
            chk("bram_en", 32'(ben), 32'(c < B));
            if (c < B) chk("bram_addr", badr, base + 32'(c));
            chk("out_valid", 32'(ov), 32'(k >= 0 && k < B));
            if (k >= 0 && k < B) chk("out_data", od, mem_word(base + 32'(k)));
            chk("burst_done", 32'(bd), 32'(k == B - 1));
            chk("req_ready", 32'(rr), 32'(c == L + B + 1));
            chk("busy", 32'(bz), 32'(c != L + B + 1));
            ndone += int'(bd);
        end
        chk("done_count", 32'(ndone), 32'd1);
    endtask

    initial begin
        logic rr, ben, ov, bd, bz;
        logic [31:0] badr, od, a;
        int nov;

        rst_n = 1'b0;
        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        drive(2, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        sample(0, rr, ben, badr, ov, od, bd, bz);
        chk("rst_req_ready", 32'(rr), 32'd1);
        chk("rst_bram_en", 32'(ben), 32'd0);
        chk("rst_out_valid", 32'(ov), 32'd0);
        chk("rst_busy", 32'(bz), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic fill, then unaligned address in the same line.
        issue_req(0, 32'h0000_0040);
        check_burst(0, 32'h0000_0040, 1'b0, 32'h0);
        issue_req(0, 32'h0000_005C);
        check_burst(0, 32'h0000_005C, 1'b0, 32'h0);

        // Request held during a burst is taken in the first idle cycle.
        issue_req(0, 32'h0000_0040);
        check_burst(0, 32'h0000_0040, 1'b1, 32'h0000_0100);
        check_burst(0, 32'h0000_0100, 1'b0, 32'h0);

        // Top of the BRAM: 8184..8191 with no wrap.
        issue_req(0, 32'h0000_7FE0);
        check_burst(0, 32'h0000_7FE0, 1'b0, 32'h0);

        // Asynchronous reset after the third issue.
        issue_req(0, 32'h0000_0040);
        @(negedge clk);
        drive(0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        sample(0, rr, ben, badr, ov, od, bd, bz);
        chk("arst_req_ready", 32'(rr), 32'd1);
        chk("arst_bram_en", 32'(ben), 32'd0);
        chk("arst_bram_addr", badr, 32'd0);
        chk("arst_out_valid", 32'(ov), 32'd0);
        chk("arst_out_data", od, 32'd0);
        chk("arst_burst_done", 32'(bd), 32'd0);
        chk("arst_busy", 32'(bz), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nov = 0;
        repeat (20) begin
            @(negedge clk);
            sample(0, rr, ben, badr, ov, od, bd, bz);
            nov += int'(ov);
        end
        chk("post_reset_no_valid", 32'(nov), 32'd0);
        issue_req(0, 32'h0000_0040);
        check_burst(0, 32'h0000_0040, 1'b0, 32'h0);

        // Random addresses on all three geometries.
        for (int n = 0; n < 3; n++) begin
            a = $urandom;
            issue_req(0, a);
            check_burst(0, a, 1'b0, 32'h0);
        end
        for (int n = 0; n < 4; n++) begin
            a = $urandom;
            issue_req(1, a);
            check_burst(1, a, 1'b0, 32'h0);
        end
        a = $urandom;
        issue_req(1, a);
        check_burst(1, a, 1'b1, 32'h0000_7FF0);
        check_burst(1, 32'h0000_7FF0, 1'b0, 32'h0);
        for (int n = 0; n < 2; n++) begin
            a = $urandom;
            issue_req(2, a);
            check_burst(2, a, 1'b0, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
